// File: rtl/mem_pkg.sv
// Shared memory-system constants and the read tag carried alongside every
// outstanding packet-memory read.
package mem_pkg;

    localparam int ADDR_W     = 12;
    localparam int BLOCK_BITS = 32;
    localparam int NUM_PORTS  = 4;
    localparam int PORT_W     = $clog2(NUM_PORTS);

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } rd_tag_t;

endpackage

// File: rtl/mem_rd_sched_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr_i
// upward, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    // N is a power of two, so PW-bit addition wraps exactly at N.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = ptr_i + PW'(i);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_rd_sched.sv
// Round-robin scheduler for the shared packet-memory read port and the
// free-list free port; read responses are steered back by a latency-matched tag pipe.
module mem_rd_sched #(
    parameter int N          = mem_pkg::NUM_PORTS,
    parameter int RD_LAT     = 2,
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int BLOCK_BITS = mem_pkg::BLOCK_BITS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N-1:0]                    rd_req_i,
    input  logic [N-1:0][ADDR_W-1:0]        rd_addr_i,
    output logic [N-1:0]                    rd_gnt_o,
    output logic [N-1:0]                    rd_rvalid_o,
    output logic [N-1:0][BLOCK_BITS-1:0]    rd_rdata_o,
    input  logic                            mem_busy_i,
    output logic                            mem_re_o,
    output logic [ADDR_W-1:0]               mem_raddr_o,
    input  logic                            mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0]           mem_rdata_i,
    input  logic [N-1:0]                    free_req_i,
    input  logic [N-1:0][ADDR_W-1:0]        free_idx_i,
    output logic [N-1:0]                    free_gnt_o,
    output logic                            free_req_o,
    output logic [ADDR_W-1:0]               free_block_idx_o,
    output logic                            err_o
);

    import mem_pkg::*;

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(RD_LAT + 1);

    // Handshake: a requester holds req (and its addr/idx) stable until it sees
    // its gnt bit high in the same cycle; that cycle is the transfer.

    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         free_ptr_q, free_ptr_d;
    logic [N-1:0]          rd_req_eff;
    logic [N-1:0]          rd_pick_gnt, free_pick_gnt;
    logic [PW-1:0]         rd_idx, free_idx;
    logic                  rd_any, free_any;
    logic                  issue;
    rd_tag_t [RD_LAT-1:0]  tag_q, tag_d;
    rd_tag_t               tail;
    logic [CW-1:0]         mask_q, mask_d;
    logic                  err_q, err_d;
    logic                  free_req_q, free_req_d;
    logic [ADDR_W-1:0]     free_blk_q, free_blk_d;

    assign rd_req_eff = mem_busy_i ? '0 : rd_req_i;

    rr_pick #(.N(N), .PW(PW)) u_rd_pick (
        .req_i (rd_req_eff),
        .ptr_i (rd_ptr_q),
        .gnt_o (rd_pick_gnt),
        .idx_o (rd_idx),
        .any_o (rd_any)
    );

    rr_pick #(.N(N), .PW(PW)) u_free_pick (
        .req_i (free_req_i),
        .ptr_i (free_ptr_q),
        .gnt_o (free_pick_gnt),
        .idx_o (free_idx),
        .any_o (free_any)
    );

    assign issue = rd_any & ~rst;
    assign tail  = tag_q[RD_LAT-1];

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        free_ptr_d = free_ptr_q;
        tag_d      = tag_q;
        mask_d     = mask_q;
        err_d      = err_q;
        free_req_d = free_any;
        free_blk_d = free_blk_q;

        if (issue) begin
            rd_ptr_d = rd_idx + PW'(1);
        end

        tag_d[0].valid = issue;
        tag_d[0].port  = rd_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // Responses to reads in flight across reset arrive against an
        // invalid tail; the mask window keeps them from being flagged.
        if (mask_q != '0) begin
            mask_d = mask_q - CW'(1);
        end else if (mem_rvalid_i != tail.valid) begin
            err_d = 1'b1;
        end

        if (free_any) begin
            free_blk_d = free_idx_i[free_idx];
            free_ptr_d = free_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            free_ptr_q <= '0;
            tag_q      <= '0;
            mask_q     <= CW'(RD_LAT);
            err_q      <= 1'b0;
            free_req_q <= 1'b0;
            free_blk_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            free_ptr_q <= free_ptr_d;
            tag_q      <= tag_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            free_req_q <= free_req_d;
            free_blk_q <= free_blk_d;
        end
    end

    always_comb begin
        rd_rvalid_o = '0;
        if (!rst && mem_rvalid_i && tail.valid) begin
            rd_rvalid_o[tail.port] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            rd_rdata_o[i] = rst ? '0 : mem_rdata_i;
        end
    end

    assign rd_gnt_o         = rst ? '0 : rd_pick_gnt;
    assign mem_re_o         = issue;
    assign mem_raddr_o      = issue ? rd_addr_i[rd_idx] : '0;
    assign free_gnt_o       = rst ? '0 : free_pick_gnt;
    assign free_req_o       = free_req_q & ~rst;
    assign free_block_idx_o = rst ? '0 : free_blk_q;
    assign err_o            = err_q & ~rst;

endmodule
